// File: rtl/enemy_pkg.sv
// Shared types and constants for the per-enemy motion generator.
package enemy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_STATION,
    ST_DIVE,
    ST_DEAD
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SWEEP = 2'b01,
    MODE_DIVE  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam logic [1:0] PHASE_RIGHT = 2'b00;
  localparam logic [1:0] PHASE_NONE  = 2'b01;
  localparam logic [1:0] PHASE_LEFT  = 2'b10;

  localparam logic [5:0] TITLE_LEVEL = 6'b000001;

endpackage

// File: rtl/enemy_axis_bounce.sv
// One-axis position step with clamped bounce at the min/max screen bounds.
module enemy_axis_bounce #(
  parameter int COORD_W = 10,
  parameter int MIN_POS = 5,
  parameter int MAX_POS = 639,
  parameter int HALF    = 25,
  parameter int SPEED   = 2
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_left_i,
  output logic [COORD_W-1:0] pos_o,
  output logic               dir_left_o
);

  localparam int EW = COORD_W + 2;

  logic [EW-1:0] pos_w;
  assign pos_w = {2'b00, pos_i};

  // Compares are done on widened values so pos-HALF can never underflow.
  always_comb begin
    pos_o      = pos_i;
    dir_left_o = dir_left_i;
    if (!dir_left_i) begin
      if (pos_w + EW'(HALF + SPEED) > EW'(MAX_POS)) begin
        pos_o      = COORD_W'(MAX_POS - HALF);
        dir_left_o = 1'b1;
      end else begin
        pos_o = pos_i + COORD_W'(SPEED);
      end
    end else begin
      if (pos_w < EW'(MIN_POS + HALF + SPEED)) begin
        pos_o      = COORD_W'(MIN_POS + HALF);
        dir_left_o = 1'b0;
      end else begin
        pos_o = pos_i - COORD_W'(SPEED);
      end
    end
  end

endmodule

// File: rtl/enemy_motion_gen.sv
// Per-enemy motion controller: enter, hold/sweep/dive, hit with timed respawn.
module enemy_motion_gen
  import enemy_pkg::*;
#(
  parameter int COORD_W        = 10,
  parameter int X_MIN          = 5,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int HALF_W         = 25,
  parameter int HALF_H         = 30,
  parameter int ENTER_SPEED    = 3,
  parameter int SWEEP_SPEED    = 2,
  parameter int DIVE_SPEED     = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int DWELL_W        = 8
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [5:0]         level,
  input  logic [5:0]         jetlevel,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] X_orig,
  input  logic [COORD_W-1:0] Y_orig,
  input  logic [COORD_W-1:0] target_Y,
  input  logic [DWELL_W-1:0] dive_dwell,
  input  logic               hit,
  output logic [COORD_W-1:0] EnemyX,
  output logic [COORD_W-1:0] EnemyY,
  output logic [1:0]         phase,
  output logic               alive,
  output state_e             state_dbg
);

  localparam int CW1 = COORD_W + 1;
  localparam int RW  = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);

  localparam logic signed [COORD_W:0] VEL_R = CW1'(SWEEP_SPEED);
  localparam logic signed [COORD_W:0] VEL_L = -VEL_R;

  state_e                    state_q;
  logic [COORD_W-1:0]        x_q, y_q;
  logic signed [COORD_W:0]   xvel_q;
  logic                      alive_q;
  logic [DWELL_W-1:0]        dwell_q;
  logic [RW-1:0]             respawn_q;

  logic [CW1-1:0]     enter_sum, dive_sum;
  logic [COORD_W-1:0] dive_y;
  logic               dive_off, sweep_mode, is_title, frozen, hit_ok;
  logic [COORD_W-1:0] bounce_x;
  logic               bounce_left;

  assign enter_sum  = {1'b0, y_q} + CW1'(ENTER_SPEED);
  assign dive_sum   = {1'b0, y_q} + CW1'(DIVE_SPEED);
  // Saturate instead of wrapping if a dive ever runs past the coordinate range.
  assign dive_y     = dive_sum[COORD_W] ? '1 : dive_sum[COORD_W-1:0];
  assign dive_off   = {1'b0, y_q} > CW1'(Y_MAX + HALF_H);
  assign sweep_mode = (mode == MODE_SWEEP) || (mode == MODE_DIVE);
  assign is_title   = (level == TITLE_LEVEL);
  assign frozen     = (level != jetlevel) && (state_q != ST_IDLE);
  assign hit_ok     = hit && (state_q inside {ST_ENTER, ST_STATION, ST_DIVE});

  enemy_axis_bounce #(
    .COORD_W (COORD_W),
    .MIN_POS (X_MIN),
    .MAX_POS (X_MAX),
    .HALF    (HALF_W),
    .SPEED   (SWEEP_SPEED)
  ) u_x_bounce (
    .pos_i      (x_q),
    .dir_left_i (xvel_q[COORD_W]),
    .pos_o      (bounce_x),
    .dir_left_o (bounce_left)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= X_orig;
      y_q       <= Y_orig;
      xvel_q    <= '0;
      alive_q   <= 1'b0;
      dwell_q   <= '0;
      respawn_q <= '0;
    end else if (is_title) begin
      state_q   <= ST_IDLE;
      x_q       <= X_orig;
      y_q       <= Y_orig;
      xvel_q    <= '0;
      alive_q   <= 1'b0;
      dwell_q   <= '0;
      respawn_q <= '0;
    end else if (hit_ok) begin
      state_q   <= ST_DEAD;
      alive_q   <= 1'b0;
      xvel_q    <= '0;
      respawn_q <= RW'(RESPAWN_FRAMES);
    end else if (!frozen) begin
      case (state_q)
        ST_IDLE: begin
          if (level == jetlevel) begin
            state_q <= ST_ENTER;
            alive_q <= 1'b1;
          end
        end
        ST_ENTER: begin
          xvel_q <= '0;
          if (enter_sum >= {1'b0, target_Y}) begin
            y_q     <= target_Y;
            state_q <= ST_STATION;
            dwell_q <= '0;
          end else begin
            y_q <= enter_sum[COORD_W-1:0];
          end
        end
        ST_STATION: begin
          if (mode == MODE_DIVE && dwell_q == dive_dwell) begin
            state_q <= ST_DIVE;
            xvel_q  <= '0;
          end else begin
            if (mode == MODE_DIVE) dwell_q <= dwell_q + DWELL_W'(1);
            if (sweep_mode) begin
              x_q    <= bounce_x;
              xvel_q <= bounce_left ? VEL_L : VEL_R;
            end else begin
              xvel_q <= '0;
            end
          end
        end
        ST_DIVE: begin
          xvel_q <= '0;
          if (dive_off) begin
            x_q     <= X_orig;
            y_q     <= Y_orig;
            state_q <= ST_ENTER;
          end else begin
            y_q <= dive_y;
          end
        end
        ST_DEAD: begin
          // A zero respawn count never reaches 1, so the enemy stays dead.
          if (respawn_q == RW'(1)) begin
            respawn_q <= '0;
            x_q       <= X_orig;
            y_q       <= Y_orig;
            xvel_q    <= '0;
            alive_q   <= (level == jetlevel);
            state_q   <= (level == jetlevel) ? ST_ENTER : ST_IDLE;
          end else if (respawn_q != '0) begin
            respawn_q <= respawn_q - RW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    phase = PHASE_NONE;
    if (xvel_q[COORD_W])     phase = PHASE_LEFT;
    else if (xvel_q != '0)   phase = PHASE_RIGHT;
  end

  assign EnemyX    = x_q;
  assign EnemyY    = y_q;
  assign alive     = alive_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_enemy_motion_gen.sv
// Directed bench for enemy_motion_gen: vector table plus multi-frame sequences.
module tb_enemy_motion_gen;
  import enemy_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b0;
  logic [5:0] level     = 6'b0;
  logic [5:0] jetlevel  = 6'b000010;
  logic [1:0] mode      = 2'b00;
  logic [9:0] X_orig    = 10'd600;
  logic [9:0] Y_orig    = 10'd94;
  logic [9:0] target_Y  = 10'd100;
  logic [7:0] dive_dwell = 8'd2;
  logic       hit       = 1'b0;
  logic [9:0] EnemyX, EnemyY;
  logic [1:0] phase;
  logic       alive;
  state_e     state_dbg;

  int checks   = 0;
  int failures = 0;

  enemy_motion_gen dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .level      (level),
    .jetlevel   (jetlevel),
    .mode       (mode),
    .X_orig     (X_orig),
    .Y_orig     (Y_orig),
    .target_Y   (target_Y),
    .dive_dwell (dive_dwell),
    .hit        (hit),
    .EnemyX     (EnemyX),
    .EnemyY     (EnemyY),
    .phase      (phase),
    .alive      (alive),
    .state_dbg  (state_dbg)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [5:0] level;
    logic [1:0] mode;
    logic       hit;
    state_e     st;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] ph;
    logic       alive;
  } vec_t;

  vec_t tbl[28];

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input state_e st, input int x, input int y,
                         input int ph, input int al);
    chk({tag, ".state"}, int'(state_dbg), int'(st));
    chk({tag, ".x"}, int'(EnemyX), x);
    chk({tag, ".y"}, int'(EnemyY), y);
    chk({tag, ".phase"}, int'(phase), ph);
    chk({tag, ".alive"}, int'(alive), al);
  endtask

  initial begin
    int n;
    int bad;
    int last_y;

    // Origin (600,94), target 100, dwell 2: short enter, sweep into the right wall.
    tbl[0]  = '{6'b000010, 2'd1, 1'b0, ST_ENTER,   10'd600, 10'd94,  2'b01, 1'b1};
    tbl[1]  = '{6'b000010, 2'd1, 1'b0, ST_ENTER,   10'd600, 10'd97,  2'b01, 1'b1};
    tbl[2]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd600, 10'd100, 2'b01, 1'b1};
    tbl[3]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd602, 10'd100, 2'b00, 1'b1};
    tbl[4]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd604, 10'd100, 2'b00, 1'b1};
    tbl[5]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd606, 10'd100, 2'b00, 1'b1};
    tbl[6]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd608, 10'd100, 2'b00, 1'b1};
    tbl[7]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd610, 10'd100, 2'b00, 1'b1};
    tbl[8]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd612, 10'd100, 2'b00, 1'b1};
    tbl[9]  = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd614, 10'd100, 2'b00, 1'b1};
    tbl[10] = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd614, 10'd100, 2'b10, 1'b1};
    tbl[11] = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd612, 10'd100, 2'b10, 1'b1};
    tbl[12] = '{6'b000100, 2'd1, 1'b0, ST_STATION, 10'd612, 10'd100, 2'b10, 1'b1};
    tbl[13] = '{6'b000100, 2'd1, 1'b0, ST_STATION, 10'd612, 10'd100, 2'b10, 1'b1};
    tbl[14] = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd610, 10'd100, 2'b10, 1'b1};
    tbl[15] = '{6'b000010, 2'd0, 1'b0, ST_STATION, 10'd610, 10'd100, 2'b01, 1'b1};
    tbl[16] = '{6'b000010, 2'd1, 1'b0, ST_STATION, 10'd612, 10'd100, 2'b00, 1'b1};
    tbl[17] = '{6'b000010, 2'd2, 1'b0, ST_STATION, 10'd614, 10'd100, 2'b00, 1'b1};
    tbl[18] = '{6'b000010, 2'd2, 1'b0, ST_STATION, 10'd614, 10'd100, 2'b10, 1'b1};
    tbl[19] = '{6'b000010, 2'd2, 1'b0, ST_DIVE,    10'd614, 10'd100, 2'b01, 1'b1};
    tbl[20] = '{6'b000010, 2'd2, 1'b0, ST_DIVE,    10'd614, 10'd104, 2'b01, 1'b1};
    tbl[21] = '{6'b000010, 2'd2, 1'b1, ST_DEAD,    10'd614, 10'd104, 2'b01, 1'b0};
    tbl[22] = '{6'b000010, 2'd2, 1'b1, ST_DEAD,    10'd614, 10'd104, 2'b01, 1'b0};
    tbl[23] = '{6'b000001, 2'd2, 1'b0, ST_IDLE,    10'd600, 10'd94,  2'b01, 1'b0};
    tbl[24] = '{6'b000010, 2'd3, 1'b0, ST_ENTER,   10'd600, 10'd94,  2'b01, 1'b1};
    tbl[25] = '{6'b000010, 2'd3, 1'b0, ST_ENTER,   10'd600, 10'd97,  2'b01, 1'b1};
    tbl[26] = '{6'b000010, 2'd3, 1'b0, ST_STATION, 10'd600, 10'd100, 2'b01, 1'b1};
    tbl[27] = '{6'b000010, 2'd3, 1'b0, ST_STATION, 10'd600, 10'd100, 2'b01, 1'b1};

    // Reset values while reset is held.
    step();
    chk_all("reset", ST_IDLE, 600, 94, 1, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      level = tbl[i].level;
      mode  = tbl[i].mode;
      hit   = tbl[i].hit;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].st, int'(tbl[i].x), int'(tbl[i].y),
              int'(tbl[i].ph), int'(tbl[i].alive));
    end
    hit = 1'b0;

    // Enter from Y=0 to target 100 at 3 px/frame.
    Reset_n  = 1'b0;
    X_orig   = 10'd320;
    Y_orig   = 10'd0;
    target_Y = 10'd100;
    mode     = 2'd0;
    level    = 6'b000010;
    step();
    Reset_n = 1'b1;
    step();
    chk("enter.start_state", int'(state_dbg), int'(ST_ENTER));
    for (int i = 0; i < 33; i++) step();
    chk("enter.y33", int'(EnemyY), 99);
    chk("enter.state33", int'(state_dbg), int'(ST_ENTER));
    step();
    chk_all("enter34", ST_STATION, 320, 100, 1, 1);

    // Dive loop: dwell of 10 sweeps, then descend until Y passes 509.
    mode       = 2'd2;
    dive_dwell = 8'd10;
    n = 0;
    while (state_dbg != ST_DIVE && n < 50) begin
      step();
      n++;
    end
    chk("dive.frames_to_dive", n, 11);
    chk("dive.x_after_sweeps", int'(EnemyX), 340);
    chk("dive.phase", int'(phase), 1);
    n = 0;
    last_y = 0;
    while (state_dbg == ST_DIVE && n < 200) begin
      last_y = int'(EnemyY);
      step();
      n++;
    end
    chk("dive.frames", n, 104);
    chk("dive.last_y", last_y, 512);
    chk_all("dive.reload", ST_ENTER, 320, 0, 1, 1);

    // Hit in STATION, second hit while dead ignored, respawn after 60 frames.
    mode = 2'd0;
    n = 0;
    while (state_dbg != ST_STATION && n < 50) begin
      step();
      n++;
    end
    chk("hit.frames_to_station", n, 34);
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk_all("hit.dead", ST_DEAD, 320, 100, 1, 0);
    bad = 0;
    for (int i = 1; i < 60; i++) begin
      if (i == 30) hit = 1'b1;
      step();
      hit = 1'b0;
      if (alive !== 1'b0 || state_dbg != ST_DEAD) bad++;
    end
    chk("hit.dead_frames_bad", bad, 0);
    step();
    chk_all("hit.respawn", ST_ENTER, 320, 0, 1, 1);

    // Async reset mid-dive, asserted between clock edges.
    mode       = 2'd2;
    dive_dwell = 8'd0;
    n = 0;
    while (state_dbg != ST_STATION && n < 50) begin
      step();
      n++;
    end
    step();
    chk("areset.in_dive", int'(state_dbg), int'(ST_DIVE));
    for (int i = 0; i < 3; i++) step();
    chk("areset.dive_y", int'(EnemyY), 112);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all("areset", ST_IDLE, 320, 0, 1, 0);
    step();
    Reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_motion_gen.md
Name: enemy_motion_gen

Overview:
- Parametrised successor to the per-enemy motion controller; one instance drives one enemy sprite.
- Supports three motion modes (HOLD, SWEEP, DIVE), clamped bounces, hit/death with timed respawn, and a registered tilt phase.
- Instantiated N times by the colour-mapper/level logic; outputs feed the sprite renderer and the collision checker.

Parameters:
- COORD_W, 10, coordinate width (unsigned pixels)
- X_MIN, 5, left screen bound
- X_MAX, 639, right screen bound
- Y_MAX, 479, bottom screen bound
- HALF_W, 25, half sprite width
- HALF_H, 30, half sprite height
- ENTER_SPEED, 3, px/frame descent to target_Y
- SWEEP_SPEED, 2, px/frame horizontal sweep
- DIVE_SPEED, 4, px/frame dive descent
- RESPAWN_FRAMES, 60, dead time in frames; 0 = never respawn
- DWELL_W, 8, width of dive_dwell and the dwell counter

Ports:
- frame_clk  in  1  frame-rate clock; all state advances once per frame
- Reset_n  in  1  asynchronous active-low reset
- level  in  6  current one-hot game level (6'b000001 = title screen)
- jetlevel  in  6  level in which this enemy is active
- mode  in  2  00 HOLD, 01 SWEEP, 10 DIVE, 11 treated as HOLD
- X_orig, Y_orig  in  COORD_W each  spawn centre
- target_Y  in  COORD_W  station row
- dive_dwell  in  DWELL_W  frames spent in STATION before diving (DIVE mode)
- hit  in  1  one-frame pulse from collision logic
- EnemyX, EnemyY  out  COORD_W each  sprite centre
- phase  out  2  00 moving right, 01 no X motion, 10 moving left
- alive  out  1  sprite visible/collidable

Behaviour:
- Outputs registered; each change is visible one frame_clk after the causing condition.
- Reset (Reset_n=0, async): state IDLE, EnemyX=X_orig, EnemyY=Y_orig, X motion 0, phase=01, alive=0, dwell and respawn counters 0.
- Per-frame priority: title (level==6'b000001) > hit > level!=jetlevel freeze > normal FSM.
- Title, from any state: go to IDLE, reload origin, motion 0, alive=0, counters cleared.
- Freeze (level!=jetlevel, not IDLE): position, state, counters, phase all hold.
- IDLE: when level==jetlevel, go to ENTER, alive=1.
- ENTER: X motion 0.
  - If EnemyY+ENTER_SPEED >= target_Y: EnemyY=target_Y exactly (no overshoot), go to STATION, dwell=0.
  - Else EnemyY += ENTER_SPEED.
- STATION, HOLD: no motion.
- STATION, SWEEP/DIVE: first frame direction is right; X steps by ±SWEEP_SPEED.
  - Right bounce: if X+HALF_W+SWEEP_SPEED > X_MAX, set X=X_MAX-HALF_W and direction left.
  - Left bounce: if X-HALF_W < X_MIN+SWEEP_SPEED, set X=X_MIN+HALF_W and direction right.
  - The bounce frame reports the new direction.
- STATION, DIVE mode: dwell increments each frame; when dwell==dive_dwell, go to DIVE, X motion 0.
- DIVE: EnemyY += DIVE_SPEED, computed at COORD_W+1 bits, no wrap.
  - When EnemyY-HALF_H > Y_MAX: reload origin and go to ENTER (looping attack).
- hit in ENTER/STATION/DIVE: go to DEAD, alive=0, motion 0, respawn=RESPAWN_FRAMES. hit is ignored in IDLE and DEAD.
- DEAD: respawn decrements each frame.
  - At 0: reload origin; go to ENTER if level==jetlevel, else IDLE.
  - RESPAWN_FRAMES=0 holds DEAD until title.
- phase derived from the registered X motion: 0 gives 01, negative gives 10, positive gives 00. Fully assigned every cycle; no latches.
- Mode changes take effect next frame. Leaving DIVE mode while in DIVE completes the dive.

Decomposition:
- Package enemy_pkg: state enum (IDLE, ENTER, STATION, DIVE, DEAD), mode enum, phase codes, TITLE_LEVEL=6'b000001.
- Sub-module enemy_axis_bounce: one-axis position/direction step with clamp at min/max. Parametrised by COORD_W, HALF, SPEED; used for the X sweep.

Test Plan:
- Enter: Y_orig=0, target_Y=100, level=jetlevel=6'b000010 -> EnemyY=99 after 33 frames, =100 at frame 34, state STATION, phase=01.
- Sweep bounce: SWEEP, X reaches 612 moving right -> next 614, then stays 614 with phase=10, then 612.
- Dive loop: DIVE, dive_dwell=10, target_Y=100 -> 10 frames in STATION, then Y+=4/frame until Y>509, then origin reload and ENTER.
- Hit/respawn: hit pulse in STATION -> alive=0 next frame, held 60 frames, then EnemyX/Y=origin, ENTER, alive=1. Second hit during DEAD ignored.
- Freeze/title: level switches to 6'b000100 mid-sweep -> X, phase held. Level 6'b000001 -> IDLE, origin, alive=0.
- Async reset: Reset_n low mid-DIVE, between clock edges -> outputs immediately at reset values, no frame_clk edge needed.
